// File: rtl/mult_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mult_pkg;

    localparam int unsigned OP1_W = 32;
    localparam int unsigned OP2_W = 64;
    localparam int unsigned RES_W = 64;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 6;
    // {A, Q, q-1} Booth accumulator; the divider reuses it as {rem[32:0], quo[31:0]}
    localparam int unsigned ACC_W = 2 * OP1_W + 1;

    // Reported for divide-by-zero and quotient overflow
    localparam logic [RES_W-1:0] ERR_RESULT = {RES_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract/keep the multiplicand, then shift right.
module booth_step
    import mult_pkg::*;
(
    input  logic [ACC_W-1:0] acc_in,
    input  logic [OP1_W-1:0] mcand,
    output logic [ACC_W-1:0] acc_out
);

    logic [OP1_W:0] a_ext;
    logic [OP1_W:0] m_ext;
    logic [OP1_W:0] sum;

    // Sum is kept one bit wider so subtracting the most negative multiplicand cannot
    // wrap; its true sign bit becomes the fill bit of the arithmetic shift.
    always_comb begin
        a_ext = {acc_in[ACC_W-1], acc_in[ACC_W-1 -: OP1_W]};
        m_ext = {mcand[OP1_W-1], mcand};
        case (acc_in[1:0])
            2'b01:   sum = a_ext + m_ext;
            2'b10:   sum = a_ext - m_ext;
            default: sum = a_ext;
        endcase
        acc_out = {sum, acc_in[OP1_W:1]};
    end

endmodule

// File: rtl/multiplier.sv
// Sequential signed multiply (Booth) / signed divide (restoring) unit, 32 cycles per op.
module multiplier
    import mult_pkg::*;
(
    output logic [RES_W-1:0] result,
    output logic             valid,
    input  logic [OP1_W-1:0] opera1,
    input  logic [OP2_W-1:0] opera2,
    input  logic             muordi,
    input  logic             clock,
    input  logic             reset,
    input  logic             start
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [OP1_W-1:0]   mcand_q, mcand_d;
    logic               is_div_q, is_div_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               err_q, err_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               valid_q, valid_d;

    logic [ACC_W-1:0]   booth_acc;
    logic [ACC_W-1:0]   div_acc;
    logic [RES_W-1:0]   div_result;
    logic [OP2_W-1:0]   dvd_mag;
    logic [OP1_W-1:0]   dvs_mag;
    logic [OP1_W:0]     shifted;
    logic [OP1_W+1:0]   diff;
    logic               ge;
    logic [OP1_W-1:0]   quo_mag, rem_mag, quo_s, rem_s;
    logic               ovf;

    booth_step u_booth (
        .acc_in  (acc_q),
        .mcand   (mcand_q),
        .acc_out (booth_acc)
    );

    // Restoring divide step and final sign fix-up / overflow detection
    always_comb begin
        dvd_mag = opera2[OP2_W-1] ? -opera2 : opera2;
        dvs_mag = opera1[OP1_W-1] ? -opera1 : opera1;
        shifted = acc_q[2*OP1_W-1:OP1_W-1];
        diff    = {1'b0, shifted} - {2'b00, mcand_q};
        ge      = ~diff[OP1_W+1];
        div_acc = {(ge ? diff[OP1_W:0] : shifted), acc_q[OP1_W-2:0], ge};
        quo_mag = div_acc[OP1_W-1:0];
        rem_mag = div_acc[2*OP1_W-1:OP1_W];
        quo_s   = neg_quo_q ? -quo_mag : quo_mag;
        rem_s   = neg_rem_q ? -rem_mag : rem_mag;
        ovf     = err_q | (neg_quo_q ? (quo_mag > 32'h8000_0000) : quo_mag[OP1_W-1]);
        div_result = ovf ? ERR_RESULT : {rem_s, quo_s};
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        err_d     = err_q;
        result_d  = result_q;
        valid_d   = valid_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = BUSY;
                    count_d  = CNT_W'(ITER);
                    valid_d  = 1'b0;
                    result_d = '0;
                    is_div_d = muordi;
                    if (muordi) begin
                        mcand_d   = dvs_mag;
                        acc_d     = {1'b0, dvd_mag};
                        neg_quo_d = opera2[OP2_W-1] ^ opera1[OP1_W-1];
                        neg_rem_d = opera2[OP2_W-1];
                        // Quotient would need more than 32 bits (also catches divisor 0)
                        err_d     = dvd_mag[OP2_W-1:OP1_W] >= dvs_mag;
                    end else begin
                        mcand_d   = opera1;
                        acc_d     = {{OP1_W{1'b0}}, opera2[OP1_W-1:0], 1'b0};
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        err_d     = 1'b0;
                    end
                end
            end
            BUSY: begin
                acc_d   = is_div_q ? div_acc : booth_acc;
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = is_div_q ? div_result : booth_acc[ACC_W-1:1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            err_q     <= err_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the multiply/divide unit.
module tb_multiplier;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        muordi;
    logic [31:0] opera1;
    logic [63:0] opera2;
    logic [63:0] result;
    logic        valid;

    int passed = 0;
    int total  = 0;

    multiplier dut (
        .result (result),
        .valid  (valid),
        .opera1 (opera1),
        .opera2 (opera2),
        .muordi (muordi),
        .clock  (clock),
        .reset  (reset),
        .start  (start)
    );

    always #5 clock = ~clock;

    // Pulse start for one edge, then scramble inputs to prove they were captured
    task automatic launch(input logic md, input logic [31:0] a, input logic [63:0] b);
        @(negedge clock);
        muordi = md;
        opera1 = a;
        opera2 = b;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        opera1 = $urandom;
        opera2 = {$urandom, $urandom};
        muordi = ~md;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (valid !== 1'b1 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        start  = 1'b0;
        muordi = 1'b0;
        opera1 = '0;
        opera2 = '0;
        repeat (3) @(negedge clock);
        total++;
        if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid);
        else passed++;
        total++;
        if (result !== 64'd0) $display("FAIL reset_result got %h want 0", result);
        else passed++;
        reset = 1'b1;
    endtask

    task automatic test_multiply;
        logic [31:0] a [4];
        logic [63:0] b [4];
        logic [63:0] e [4];
        int lat;
        a[0] = 32'hFFFF_FFFD; b[0] = 64'd7;                  e[0] = 64'hFFFF_FFFF_FFFF_FFEB;
        a[1] = 32'h8000_0000; b[1] = 64'h8000_0000;          e[1] = 64'h4000_0000_0000_0000;
        a[2] = 32'h7FFF_FFFF; b[2] = 64'hFFFF_FFFF_7FFF_FFFF; e[2] = 64'h3FFF_FFFF_0000_0001;
        a[3] = 32'h7FFF_FFFF; b[3] = 64'h8000_0000;          e[3] = 64'hC000_0000_8000_0000;
        for (int i = 0; i < 4; i++) begin
            launch(1'b0, a[i], b[i]);
            total++;
            if (valid !== 1'b0 || result !== 64'd0)
                $display("FAIL mul%0d_busy got valid=%b result=%h want 0/0", i, valid, result);
            else passed++;
            wait_valid(lat);
            total++;
            if (lat !== 32) $display("FAIL mul%0d_latency got %0d want 32", i, lat);
            else passed++;
            total++;
            if (result !== e[i]) $display("FAIL mul%0d_result got %h want %h", i, result, e[i]);
            else passed++;
        end
    endtask

    task automatic test_divide;
        logic [31:0] a [7];
        logic [63:0] b [7];
        logic [63:0] e [7];
        int lat;
        a[0] = 32'd7;         b[0] = 64'd100;                 e[0] = 64'h0000_0002_0000_000E;
        a[1] = 32'd7;         b[1] = -64'sd100;               e[1] = 64'hFFFF_FFFE_FFFF_FFF2;
        a[2] = 32'd0;         b[2] = 64'd55;                  e[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        a[3] = 32'd1;         b[3] = 64'h0000_0001_0000_0000; e[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        a[4] = 32'd1;         b[4] = 64'hFFFF_FFFF_8000_0000; e[4] = 64'h0000_0000_8000_0000;
        a[5] = 32'd1;         b[5] = 64'h0000_0000_8000_0000; e[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        a[6] = 32'hFFFF_FFF9; b[6] = 64'd100;                 e[6] = 64'h0000_0002_FFFF_FFF2;
        for (int i = 0; i < 7; i++) begin
            launch(1'b1, a[i], b[i]);
            wait_valid(lat);
            total++;
            if (lat !== 32) $display("FAIL div%0d_latency got %0d want 32", i, lat);
            else passed++;
            total++;
            if (result !== e[i]) $display("FAIL div%0d_result got %h want %h", i, result, e[i]);
            else passed++;
        end
        // Result must hold in DONE
        repeat (5) @(negedge clock);
        total++;
        if (valid !== 1'b1 || result !== e[6])
            $display("FAIL done_hold got valid=%b result=%h want 1/%h", valid, result, e[6]);
        else passed++;
    endtask

    task automatic test_reset_busy;
        int lat;
        launch(1'b0, 32'd5, 64'd6);
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (valid !== 1'b0 || result !== 64'd0)
            $display("FAIL abort got valid=%b result=%h want 0/0", valid, result);
        else passed++;
        // Reset wins over start on the same edge
        start  = 1'b1;
        muordi = 1'b0;
        opera1 = 32'd3;
        opera2 = 64'd3;
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        repeat (40) @(negedge clock);
        total++;
        if (valid !== 1'b0 || result !== 64'd0)
            $display("FAIL reset_priority got valid=%b result=%h want 0/0", valid, result);
        else passed++;
        // Fresh start after reset; a start while busy is ignored
        launch(1'b0, 32'd5, 64'hFFFF_FFFF_FFFF_FFFA);
        repeat (5) @(negedge clock);
        muordi = 1'b1;
        opera1 = 32'd9;
        opera2 = 64'd1000;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        wait_valid(lat);
        total++;
        if (lat !== 26) $display("FAIL restart_latency got %0d want 26", lat);
        else passed++;
        total++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFE2)
            $display("FAIL restart_result got %h want %h", result, 64'hFFFF_FFFF_FFFF_FFE2);
        else passed++;
        repeat (10) @(negedge clock);
        total++;
        if (valid !== 1'b1 || result !== 64'hFFFF_FFFF_FFFF_FFE2)
            $display("FAIL busy_start_ignored got valid=%b result=%h", valid, result);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int lat;
        // Start accepted straight from DONE
        launch(1'b0, 32'd12345, 64'd1000);
        total++;
        if (valid !== 1'b0) $display("FAIL b2b_clear got %b want 0", valid);
        else passed++;
        wait_valid(lat);
        total++;
        if (result !== 64'd12345000) $display("FAIL b2b_result got %h want %h", result, 64'd12345000);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_reset_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
